// File: rtl/mult_pipe_pkg.sv
// Shared defaults and operand-mode encoding for the pipelined multiplier.
// Imported by the interface, the stage slice and the top level.
package mult_pipe_pkg;

  localparam int MULT_WIDTH  = 32;
  localparam int MULT_TAG_W  = 5;
  localparam int MULT_STAGES = 3;

  typedef enum logic {
    MODE_UNSIGNED = 1'b0,
    MODE_SIGNED   = 1'b1
  } mult_mode_e;

endpackage

// File: rtl/mult_pipe_if.sv
// Operation/result bundle of the multiply path: issue side, result side, stall/flush and busy.
// The master drives operations; the slave (the multiplier) returns results.
interface mult_pipe_if
  import mult_pipe_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH,
  parameter int TAG_W = MULT_TAG_W
);

  logic               in_valid;
  logic               in_signed;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic [TAG_W-1:0]   in_tag;
  logic               in_ispositive;
  logic               in_iszero;
  logic               stall;
  logic               flush;
  logic               out_valid;
  logic [2*WIDTH-1:0] out_result;
  logic [TAG_W-1:0]   out_tag;
  logic               out_ispositive;
  logic               out_iszero;
  logic               busy;

  modport master (
    output in_valid, in_signed, in_a, in_b, in_tag, in_ispositive, in_iszero,
    output stall, flush,
    input  out_valid, out_result, out_tag, out_ispositive, out_iszero, busy
  );

  modport slave (
    input  in_valid, in_signed, in_a, in_b, in_tag, in_ispositive, in_iszero,
    input  stall, flush,
    output out_valid, out_result, out_tag, out_ispositive, out_iszero, busy
  );

endinterface

// File: rtl/mult_pipe_stage.sv
// One register slice of the multiply pipeline: {valid, result, tag, flags}.
// Clear beats hold; reset wipes payload too so empty slices always read zero.
module mult_pipe_stage
  import mult_pipe_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH,
  parameter int TAG_W = MULT_TAG_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               hold,
  input  logic               clear,
  input  logic               d_valid,
  input  logic [2*WIDTH-1:0] d_result,
  input  logic [TAG_W-1:0]   d_tag,
  input  logic               d_ispositive,
  input  logic               d_iszero,
  output logic               q_valid,
  output logic [2*WIDTH-1:0] q_result,
  output logic [TAG_W-1:0]   q_tag,
  output logic               q_ispositive,
  output logic               q_iszero
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q_valid      <= 1'b0;
      q_result     <= '0;
      q_tag        <= '0;
      q_ispositive <= 1'b0;
      q_iszero     <= 1'b0;
    end else if (clear) begin
      q_valid      <= 1'b0;
      q_result     <= '0;
      q_tag        <= '0;
      q_ispositive <= 1'b0;
      q_iszero     <= 1'b0;
    end else if (!hold) begin
      q_valid      <= d_valid;
      q_result     <= d_result;
      q_tag        <= d_tag;
      q_ispositive <= d_ispositive;
      q_iszero     <= d_iszero;
    end
  end

endmodule

// File: rtl/mult_pipe.sv
// Pipelined WIDTHxWIDTH multiplier with signed/unsigned mode, stall and flush.
// Stage 1 registers the product; the remaining slices only delay it.
module mult_pipe
  import mult_pipe_pkg::*;
#(
  parameter int WIDTH  = MULT_WIDTH,
  parameter int STAGES = MULT_STAGES,
  parameter int TAG_W  = MULT_TAG_W
) (
  input  logic          clock,
  input  logic          reset,
  mult_pipe_if.slave    bus
);

  // Extending to 2*WIDTH directly gives the same low 2*WIDTH bits as a
  // (WIDTH+1)-bit extension followed by truncation of the wider product.
  function automatic logic signed [2*WIDTH-1:0] extend(input logic [WIDTH-1:0] op,
                                                       input mult_mode_e mode);
    if (mode == MODE_SIGNED) return $signed({{WIDTH{op[WIDTH-1]}}, op});
    return $signed({{WIDTH{1'b0}}, op});
  endfunction

  mult_mode_e                mode_p0;
  logic signed [2*WIDTH-1:0] a_ext_p0;
  logic signed [2*WIDTH-1:0] b_ext_p0;
  logic signed [2*WIDTH-1:0] prod_p0;

  logic [STAGES:0]    chain_vld;
  logic [2*WIDTH-1:0] chain_res  [STAGES+1];
  logic [TAG_W-1:0]   chain_tag  [STAGES+1];
  logic [STAGES:0]    chain_pos;
  logic [STAGES:0]    chain_zero;

  assign mode_p0  = mult_mode_e'(bus.in_signed);
  assign a_ext_p0 = extend(bus.in_a, mode_p0);
  assign b_ext_p0 = extend(bus.in_b, mode_p0);
  assign prod_p0  = a_ext_p0 * b_ext_p0;

  // Bubbles enter stage 1 with an all-zero payload
  assign chain_vld[0]  = bus.in_valid;
  assign chain_res[0]  = bus.in_valid ? prod_p0 : '0;
  assign chain_tag[0]  = bus.in_valid ? bus.in_tag : '0;
  assign chain_pos[0]  = bus.in_valid & bus.in_ispositive;
  assign chain_zero[0] = bus.in_valid & bus.in_iszero;

  // ---- stage boundaries p1 .. pSTAGES ----
  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    mult_pipe_stage #(
      .WIDTH (WIDTH),
      .TAG_W (TAG_W)
    ) u_stage (
      .clock        (clock),
      .reset        (reset),
      .hold         (bus.stall),
      .clear        (bus.flush),
      .d_valid      (chain_vld[s]),
      .d_result     (chain_res[s]),
      .d_tag        (chain_tag[s]),
      .d_ispositive (chain_pos[s]),
      .d_iszero     (chain_zero[s]),
      .q_valid      (chain_vld[s+1]),
      .q_result     (chain_res[s+1]),
      .q_tag        (chain_tag[s+1]),
      .q_ispositive (chain_pos[s+1]),
      .q_iszero     (chain_zero[s+1])
    );
  end

  assign bus.out_valid      = chain_vld[STAGES];
  assign bus.out_result     = chain_res[STAGES];
  assign bus.out_tag        = chain_tag[STAGES];
  assign bus.out_ispositive = chain_pos[STAGES];
  assign bus.out_iszero     = chain_zero[STAGES];
  assign bus.busy           = |chain_vld[STAGES:1];

endmodule
